div_sequencer: RTL

Multi-cycle integer divide engine and sequencer for the execute stage of the pipelined core. It accepts UDIV/SDIV operations issued in E and computes quotient and remainder with a radix-2 restoring algorithm, one bit per cycle. While busy it holds a stall request to the hazard logic so the divide instruction stays in E. It releases the result for one cycle so the instruction can advance to M with a valid result.

---
 rtl/div_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// Radix-2 restoring integer divider for the execute stage.
// Holds a stall request while it computes and pulses DoneE for one cycle with the result.
module div_sequencer #(
    parameter int WIDTH            = 32,
    parameter int ALUCONTROL_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        StartE,
    input  logic [ALUCONTROL_WIDTH-1:0] ALUControlE,
    input  logic [WIDTH-1:0]            SrcAE,
    input  logic [WIDTH-1:0]            SrcBE,
    input  logic                        FlushE,
    output logic                        StallDivE,
    output logic                        DoneE,
    output logic [WIDTH-1:0]            QuotientE,
    output logic [WIDTH-1:0]            RemainderE,
    output logic                        DivZeroE,
    output logic                        BusyE
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [ALUCONTROL_WIDTH-1:0] OP_UDIV = ALUCONTROL_WIDTH'(5'b01110);
    localparam logic [ALUCONTROL_WIDTH-1:0] OP_SDIV = ALUCONTROL_WIDTH'(5'b01111);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, nextState;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   remReg, dvdReg, dvsReg;
    logic               qNeg, rNeg;

    logic               isDiv, isSdiv, accept, lastStep;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH:0]     shifted, diff;
    logic [WIDTH-1:0]   remNext, quoNext;

    always_comb begin
        isSdiv = (ALUControlE == OP_SDIV);
        isDiv  = (ALUControlE == OP_UDIV) || isSdiv;
        accept = StartE && isDiv && (state == IDLE) && !FlushE;
        absA   = (isSdiv && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
        absB   = (isSdiv && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
    end

    // One restoring step: a non-negative trial difference means the divisor fits.
    always_comb begin
        shifted = {remReg, dvdReg[WIDTH-1]};
        diff    = shifted - {1'b0, dvsReg};
        if (!diff[WIDTH]) begin
            remNext = diff[WIDTH-1:0];
            quoNext = {dvdReg[WIDTH-2:0], 1'b1};
        end else begin
            remNext = shifted[WIDTH-1:0];
            quoNext = {dvdReg[WIDTH-2:0], 1'b0};
        end
        lastStep = (count == CNT_W'(1));
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (accept) nextState = (SrcBE == '0) ? DONE : CALC;
            CALC: begin
                if (FlushE)        nextState = IDLE;
                else if (lastStep) nextState = DONE;
            end
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
        StallDivE = (accept || (state == CALC)) && !FlushE;
        DoneE     = (state == DONE) && !FlushE;
        BusyE     = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            remReg     <= '0;
            dvdReg     <= '0;
            dvsReg     <= '0;
            qNeg       <= 1'b0;
            rNeg       <= 1'b0;
            QuotientE  <= '0;
            RemainderE <= '0;
            DivZeroE   <= 1'b0;
        end else if (accept) begin
            qNeg   <= isSdiv && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
            rNeg   <= isSdiv && SrcAE[WIDTH-1];
            dvdReg <= absA;
            dvsReg <= absB;
            remReg <= '0;
            count  <= CNT_W'(WIDTH);
            if (SrcBE == '0) begin
                QuotientE  <= '0;
                RemainderE <= SrcAE;
                DivZeroE   <= 1'b1;
            end
        end else if (state == CALC && !FlushE) begin
            remReg <= remNext;
            dvdReg <= quoNext;
            count  <= count - CNT_W'(1);
            // Results land on the edge into DONE so they are stable for the whole DONE cycle.
            if (lastStep) begin
                QuotientE  <= qNeg ? -quoNext : quoNext;
                RemainderE <= rNeg ? -remNext : remNext;
                DivZeroE   <= 1'b0;
            end
        end
    end

endmodule
